// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg
//   Shared types and helpers for the binary-to-BCD display converter.
//   - BLANK_CODE : digit code the seven-segment decoder renders unlit
//   - digit_t    : one 4-bit digit code
//   - state_t    : converter FSM states
//   - blankDigits: replaces leading zero digits with the blank code
package bcd_display_pkg;

    localparam logic [3:0] BLANK_CODE = 4'd10;

    // Width of the vector handled by blankDigits; callers zero-extend
    // their DIGITS-wide vector to this size and truncate the result.
    localparam int MAX_DIGITS = 16;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    // Walks from the top digit down; every digit above the most significant
    // nonzero one becomes blankCode. Digit 0 is never blanked so a zero value
    // still shows a single "0".
    function automatic logic [MAX_DIGITS*4-1:0] blankDigits(
        input logic [MAX_DIGITS*4-1:0] rawDigits,
        input int                      numDigits,
        input digit_t                  blankCode
    );
        logic [MAX_DIGITS*4-1:0] result;
        logic                    seenNonZero;
        result      = rawDigits;
        seenNonZero = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < numDigits) begin
                if (rawDigits[i*4 +: 4] != 4'd0) begin
                    seenNonZero = 1'b1;
                end
                if (!seenNonZero) begin
                    result[i*4 +: 4] = blankCode;
                end
            end else begin
                result[i*4 +: 4] = 4'd0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_display_converter_adjust.sv
// bcd_dabble_adjust
//   Combinational double-dabble correction: adds 3 to every nibble >= 5.
//   Ports:
//     bcdIn  - NIBBLES x 4 BCD accumulator before the shift
//     bcdOut - corrected accumulator, ready to be shifted left by one
module bcd_dabble_adjust
    import bcd_display_pkg::*;
#(
    parameter int NIBBLES = 7
) (
    input  logic [NIBBLES*4-1:0] bcdIn,
    output logic [NIBBLES*4-1:0] bcdOut
);

    digit_t nibble;

    always_comb begin
        bcdOut = bcdIn;
        nibble = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            nibble = bcdIn[i*4 +: 4];
            if (nibble >= 4'd5) begin
                bcdOut[i*4 +: 4] = nibble + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bcd_display_converter.sv
// bcd_display_converter
//   Sequential binary-to-BCD converter (shift-and-add-3) feeding the
//   per-digit seven-segment decoders. One value per handshake, WIDTH shift
//   steps, then a single FINISH cycle that loads the blanked digits.
//   Ports:
//     clk       - system clock
//     reset     - asynchronous, active-high reset
//     in_value  - binary value, sampled only on acceptance
//     in_valid  - in_value valid this cycle
//     in_ready  - high only in IDLE
//     digit_out - DIGITS x 4 digit codes, nibble 0 = least-significant digit
//     out_valid - one-cycle pulse after digit_out is updated
//     overflow  - last converted value exceeded 10^DIGITS - 1
//   Build option:
//     BCD_DISPLAY_SATURATE_EN - on overflow show all nines instead of the
//                               value modulo 10^DIGITS
//
//   state  | meaning
//   IDLE   | waiting for in_valid, in_ready high
//   SHIFT  | one adjust-and-shift step per cycle, WIDTH steps
//   FINISH | load blanked digits, overflow and out_valid
module bcd_display_converter #(
    parameter int         WIDTH      = 20,
    parameter int         DIGITS     = 6,
    parameter logic [3:0] BLANK_CODE = bcd_display_pkg::BLANK_CODE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    in_value,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DIGITS*4-1:0] digit_out,
    output logic                out_valid,
    output logic                overflow
);

    import bcd_display_pkg::*;

    // One guard nibble above the displayed digits detects overflow.
    localparam int NIBBLES = DIGITS + 1;
    localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]    LAST_STEP    = CNT_W'(WIDTH - 1);
    localparam logic [DIGITS*4-1:0] RESET_DIGITS = {{(DIGITS-1){BLANK_CODE}}, 4'd0};

    state_t               state;
    state_t               nextState;
    logic [WIDTH-1:0]     shiftReg;
    logic [NIBBLES*4-1:0] bcdAcc;
    logic [NIBBLES*4-1:0] adjusted;
    logic [CNT_W-1:0]     bitCount;
    logic                 accCarry;
    logic                 overflowNow;
    logic [DIGITS*4-1:0]  rawDigits;
    logic [DIGITS*4-1:0]  finalDigits;

    bcd_dabble_adjust #(
        .NIBBLES(NIBBLES)
    ) uAdjust (
        .bcdIn (bcdAcc),
        .bcdOut(adjusted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (bitCount == LAST_STEP) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // accCarry catches a digit shifted out of the guard nibble, which can only
    // happen if WIDTH is too large for DIGITS+1 nibbles; it still means overflow.
    always_comb begin
        overflowNow = accCarry | (bcdAcc[NIBBLES*4-1 -: 4] != 4'd0);
        rawDigits   = bcdAcc[DIGITS*4-1:0];
`ifdef BCD_DISPLAY_SATURATE_EN
        if (overflowNow) begin
            rawDigits = {DIGITS{4'd9}};
        end
`endif
        finalDigits = (DIGITS*4)'(blankDigits((MAX_DIGITS*4)'(rawDigits), DIGITS, BLANK_CODE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg  <= '0;
            bcdAcc    <= '0;
            bitCount  <= '0;
            accCarry  <= 1'b0;
            digit_out <= RESET_DIGITS;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shiftReg <= in_value;
                        bcdAcc   <= '0;
                        bitCount <= '0;
                        accCarry <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcdAcc   <= {adjusted[NIBBLES*4-2:0], shiftReg[WIDTH-1]};
                    shiftReg <= shiftReg << 1;
                    bitCount <= bitCount + CNT_W'(1);
                    if (adjusted[NIBBLES*4-1]) begin
                        accCarry <= 1'b1;
                    end
                end
                FINISH: begin
                    digit_out <= finalDigits;
                    overflow  <= overflowNow;
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_converter.sv
// tb_bcd_display_converter
//   Directed bench for bcd_display_converter at default parameters
//   (WIDTH 20, DIGITS 6). Expected digit vectors are written as hex with
//   one nibble per digit, digit5 first; 'A' is the blank code.
//   Build option: BCD_DISPLAY_SATURATE_EN selects the saturating expectation.
module tb_bcd_display_converter;

    logic        clk;
    logic        reset;
    logic [19:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] digit_out;
    logic        out_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    bcd_display_converter dut (
        .clk      (clk),
        .reset    (reset),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .digit_out(digit_out),
        .out_valid(out_valid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: offers one value, drops in_valid and scrambles in_value
    // after acceptance, then waits (bounded) for out_valid. latency = 0 means
    // no result arrived within the budget.
    task automatic doConvert(input logic [19:0] value, output logic [23:0] digits,
                             output logic ovf, output int latency);
        @(negedge clk);
        in_value = value;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = ~value;
        latency  = 0;
        digits   = '0;
        ovf      = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                latency = i;
                digits  = digit_out;
                ovf     = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (digit_out !== 24'hAAAAA0) begin
            errors++;
            $display("FAIL reset_digits: got %h expected %h", digit_out, 24'hAAAAA0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_basic();
        logic [23:0] d;
        logic        o;
        int          lat;
        doConvert(20'd16, d, o, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 21", lat);
        end
        checks++;
        if (d !== 24'hAAAA16) begin
            errors++;
            $display("FAIL basic_digits: got %h expected %h", d, 24'hAAAA16);
        end
        checks++;
        if (o !== 1'b0) begin
            errors++;
            $display("FAIL basic_overflow: got %b expected 0", o);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_on_result: got %b expected 1", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: got %b expected 0", out_valid);
        end
        checks++;
        if (digit_out !== 24'hAAAA16) begin
            errors++;
            $display("FAIL basic_hold: got %h expected %h", digit_out, 24'hAAAA16);
        end
    endtask

    task automatic test_zero_and_max();
        logic [23:0] d;
        logic        o;
        int          lat;
        doConvert(20'd0, d, o, lat);
        checks++;
        if (lat !== 21 || d !== 24'hAAAAA0 || o !== 1'b0) begin
            errors++;
            $display("FAIL zero_value: got lat %0d digits %h ovf %b expected 21 %h 0",
                     lat, d, o, 24'hAAAAA0);
        end
        doConvert(20'd999999, d, o, lat);
        checks++;
        if (lat !== 21 || d !== 24'h999999 || o !== 1'b0) begin
            errors++;
            $display("FAIL max_value: got lat %0d digits %h ovf %b expected 21 %h 0",
                     lat, d, o, 24'h999999);
        end
        doConvert(20'd123456, d, o, lat);
        checks++;
        if (lat !== 21 || d !== 24'h123456 || o !== 1'b0) begin
            errors++;
            $display("FAIL full_width: got lat %0d digits %h ovf %b expected 21 %h 0",
                     lat, d, o, 24'h123456);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] d;
        logic        o;
        int          lat;
        logic [23:0] expDigits;
`ifdef BCD_DISPLAY_SATURATE_EN
        expDigits = 24'h999999;
`else
        expDigits = 24'hA48575;
`endif
        doConvert(20'd1048575, d, o, lat);
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL overflow_latency: got %0d expected 21", lat);
        end
        checks++;
        if (d !== expDigits) begin
            errors++;
            $display("FAIL overflow_digits: got %h expected %h", d, expDigits);
        end
        checks++;
        if (o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got %b expected 1", o);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold: got %b expected 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] expVals [3];
        int          resultCount;
        int          readyLow;
        expVals[0]  = 24'hAA1000;
        expVals[1]  = 24'hAA1022;
        expVals[2]  = 24'hAA1044;
        resultCount = 0;
        readyLow    = 0;
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_value = 20'(1000 + k);
            @(posedge clk);
            #1;
            if (!in_ready) begin
                readyLow++;
            end
            if (out_valid) begin
                checks++;
                if (resultCount > 2) begin
                    errors++;
                    $display("FAIL b2b_extra_result: got result %0d at cycle %0d expected 3 total",
                             resultCount, k);
                end else if (k != 21 + 22 * resultCount || digit_out !== expVals[resultCount]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got cycle %0d digits %h expected cycle %0d digits %h",
                             resultCount, k, digit_out, 21 + 22 * resultCount, expVals[resultCount]);
                end
                resultCount++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (resultCount !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 3", resultCount);
        end
        checks++;
        if (readyLow !== 63) begin
            errors++;
            $display("FAIL b2b_ready_low: got %0d expected 63", readyLow);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] d;
        logic        o;
        int          lat;
        @(negedge clk);
        in_value = 20'd123456;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (digit_out !== 24'hAAAAA0 || in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got digits %h ready %b valid %b ovf %b expected %h 1 0 0",
                     digit_out, in_ready, out_valid, overflow, 24'hAAAAA0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        doConvert(20'd7, d, o, lat);
        checks++;
        if (lat !== 21 || d !== 24'hAAAAA7 || o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_convert: got lat %0d digits %h ovf %b expected 21 %h 0",
                     lat, d, o, 24'hAAAAA7);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_max();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
